// File: rtl/decrypt_sequencer_pkg.sv
`default_nettype none
// ==================================================================
// decrypt_pkg : shared constants, tap table and state types
// Rev 1.0
// ==================================================================
package decrypt_pkg;

  localparam logic [7:0] SPACE         = 8'h20;
  localparam logic [7:0] IN_BASE_DEF   = 8'd64;
  localparam logic [7:0] OUT_BASE_DEF  = 8'd0;
  localparam logic [7:0] MSG_LEN_DEF   = 8'd64;
  localparam logic [7:0] CHECK_LEN_DEF = 8'd9;

  localparam int NUM_TAPS = 9;
  localparam logic [6:0] TAPS [NUM_TAPS] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                             7'h69, 7'h5C, 7'h7E, 7'h7B};

  typedef enum logic [2:0] {IDLE, SEED, SEARCH, DECRYPT, PAD, DONE} state_e;
  typedef enum logic {RD_ADDR, RD_DATA} rd_phase_e;

  function automatic logic [6:0] tap_sel(input logic [3:0] idx);
    return (idx < 4'(NUM_TAPS)) ? TAPS[idx] : 7'h00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decrypt_sequencer_if.sv
`default_nettype none
// ==================================================================
// decrypt_sequencer_if : Start/Ack handshake plus data-memory bus
// Rev 1.0
// ==================================================================
interface decrypt_sequencer_if;
  logic       Start;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       Ack;
  logic [3:0] ptrn_idx;
  logic       no_match;

  modport master (input  Start, mem_rdata,
                  output mem_addr, mem_wr_en, mem_wdata, Ack, ptrn_idx, no_match);
  modport slave  (output Start, mem_rdata,
                  input  mem_addr, mem_wr_en, mem_wdata, Ack, ptrn_idx, no_match);
endinterface
`default_nettype wire

// File: rtl/decrypt_sequencer_lfsr7.sv
`default_nettype none
// ==================================================================
// lfsr7 : 7-bit Fibonacci LFSR with load and step controls
// Rev 1.0
// ==================================================================
module lfsr7 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       step_i,
  input  logic [6:0] tap_i,
  output logic [6:0] state_o
);
  logic [6:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i)      state_d = load_val_i;
    else if (step_i) state_d = {state_q[5:0], ^(state_q & tap_i)};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= '0;
    else         state_q <= state_d;
  end

  assign state_o = state_q;
endmodule
`default_nettype wire

// File: rtl/decrypt_sequencer.sv
`default_nettype none
// ==================================================================
// decrypt_sequencer : LFSR pattern search and in-memory decryption
// Rev 1.0
// ==================================================================
module decrypt_sequencer import decrypt_pkg::*; #(
  parameter logic [7:0] IN_BASE   = IN_BASE_DEF,
  parameter logic [7:0] OUT_BASE  = OUT_BASE_DEF,
  parameter logic [7:0] MSG_LEN   = MSG_LEN_DEF,
  parameter logic [7:0] CHECK_LEN = CHECK_LEN_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  decrypt_sequencer_if.master bus
);
  localparam logic [3:0] LAST_P = 4'(NUM_TAPS - 1);

  state_e     state_q, state_d;
  rd_phase_e  phase_q, phase_d;
  logic       emit_q, emit_d, skip_q, skip_d, nomatch_q, nomatch_d, start_q;
  logic [6:0] seed_q, seed_d;
  logic [3:0] p_q, p_d, ptrn_q, ptrn_d;
  logic [7:0] k_q, k_d, i_q, i_d, w_q, w_d, wdata_q, wdata_d;

  logic       lfsr_load, lfsr_step, perr, byte_done, wr_en;
  logic [6:0] lfsr_val, lfsr_s, pt;
  logic [7:0] addr, wdata, w_after;

  lfsr7 u_lfsr (
    .clk_i      (Clk),
    .rst_ni     (Reset),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_val),
    .step_i     (lfsr_step),
    .tap_i      (tap_sel(p_q)),
    .state_o    (lfsr_s)
  );

  always_comb begin
    state_d   = state_q;   phase_d   = phase_q;  emit_d  = emit_q;  skip_d = skip_q;
    seed_d    = seed_q;    p_d       = p_q;      k_d     = k_q;     i_d    = i_q;
    w_d       = w_q;       wdata_d   = wdata_q;  ptrn_d  = ptrn_q;  nomatch_d = nomatch_q;
    lfsr_load = 1'b0;      lfsr_val  = seed_q;   lfsr_step = 1'b0;
    addr      = '0;        wr_en     = 1'b0;     wdata   = '0;
    byte_done = 1'b0;      w_after   = w_q;
    pt        = bus.mem_rdata[6:0] ^ lfsr_s;
    perr      = ^bus.mem_rdata;

    case (state_q)
      IDLE, DONE: begin
        if (start_q && !bus.Start) begin
          state_d   = SEED;
          phase_d   = RD_ADDR;
          ptrn_d    = 4'hF;
          nomatch_d = 1'b0;
        end
      end
      SEED: begin
        if (phase_q == RD_ADDR) begin
          addr    = IN_BASE;
          phase_d = RD_DATA;
        end else begin
          seed_d    = bus.mem_rdata[6:0] ^ SPACE[6:0];
          lfsr_load = 1'b1;
          lfsr_val  = seed_d;
          p_d       = '0;
          k_d       = 8'd1;
          phase_d   = RD_ADDR;
          state_d   = SEARCH;
        end
      end
      SEARCH: begin
        // LFSR advances on the address cycle so byte k sees step^k(seed)
        if (phase_q == RD_ADDR) begin
          addr      = IN_BASE + k_q;
          lfsr_step = 1'b1;
          phase_d   = RD_DATA;
        end else begin
          phase_d = RD_ADDR;
          if (pt == SPACE[6:0]) begin
            if (k_q == CHECK_LEN) begin
              ptrn_d    = p_q;
              lfsr_load = 1'b1;
              i_d       = '0;
              w_d       = '0;
              skip_d    = 1'b1;
              emit_d    = 1'b0;
              state_d   = DECRYPT;
            end else begin
              k_d = k_q + 8'd1;
            end
          end else if (p_q == LAST_P) begin
            nomatch_d = 1'b1;
            state_d   = DONE;
          end else begin
            p_d       = p_q + 4'd1;
            k_d       = 8'd1;
            lfsr_load = 1'b1;
          end
        end
      end
      DECRYPT: begin
        if (emit_q) begin
          wr_en     = 1'b1;
          addr      = OUT_BASE + w_q;
          wdata     = wdata_q;
          w_d       = w_q + 8'd1;
          w_after   = w_q + 8'd1;
          emit_d    = 1'b0;
          byte_done = 1'b1;
        end else if (phase_q == RD_ADDR) begin
          addr    = IN_BASE + i_q;
          phase_d = RD_DATA;
        end else begin
          phase_d   = RD_ADDR;
          lfsr_step = 1'b1;
          if (skip_q && pt == SPACE[6:0] && !perr) begin
            byte_done = 1'b1;
          end else begin
            skip_d  = 1'b0;
            wdata_d = {perr, pt};
            emit_d  = 1'b1;
          end
        end
      end
      PAD: begin
        wr_en = 1'b1;
        addr  = OUT_BASE + w_q;
        wdata = SPACE;
        w_d   = w_q + 8'd1;
        if (w_q == MSG_LEN - 8'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // A fully emitted message skips PAD so the run never idles a cycle
    if (byte_done) begin
      if (i_q == MSG_LEN - 8'd1) state_d = (w_after == MSG_LEN) ? DONE : PAD;
      else                       i_d     = i_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;  phase_q <= RD_ADDR; emit_q <= 1'b0; skip_q <= 1'b0;
      seed_q  <= '0;    p_q     <= '0;      k_q    <= '0;   i_q    <= '0;
      w_q     <= '0;    wdata_q <= '0;      ptrn_q <= 4'hF; nomatch_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;  phase_q <= phase_d;  emit_q <= emit_d;  skip_q <= skip_d;
      seed_q  <= seed_d;   p_q     <= p_d;      k_q    <= k_d;     i_q    <= i_d;
      w_q     <= w_d;      wdata_q <= wdata_d;  ptrn_q <= ptrn_d;  nomatch_q <= nomatch_d;
      start_q <= bus.Start;
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wr_en = wr_en;
  assign bus.mem_wdata = wdata;
  assign bus.Ack       = (state_q == DONE);
  assign bus.ptrn_idx  = ptrn_q;
  assign bus.no_match  = nomatch_q;
endmodule
`default_nettype wire

// File: tb/tb_decrypt_sequencer.sv
`default_nettype none
// ==================================================================
// tb_decrypt_sequencer : directed bench with behavioural data memory
// Rev 1.0
// ==================================================================
module tb_decrypt_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  decrypt_sequencer_if bus ();
  decrypt_sequencer dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  logic [7:0] mem [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_addr = 8'h00, tb_wdata = 8'h00;
  int         wr_cnt = 0, act_cnt = 0;
  int         n_checks = 0, n_errors = 0;
  string      msg = "Mr. Watson, come here. I want to see you.";

  always @(posedge Clk) begin
    if (tb_we)              mem[tb_addr] <= tb_wdata;
    else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.mem_wr_en || bus.mem_addr != 8'h00) act_cnt <= act_cnt + 1;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] tap);
    return {s[5:0], ^(s & tap)};
  endfunction

  function automatic logic [6:0] msg_chr(input int idx);
    byte b;
    b = msg.getc(idx);
    return b[6:0];
  endfunction

  function automatic logic [6:0] plain_at(input int j, input int pre);
    if (j >= pre && j < pre + msg.len()) return msg_chr(j - pre);
    return 7'h20;
  endfunction

  task automatic tb_write(input logic [7:0] a, input logic [7:0] d);
    tb_addr = a; tb_wdata = d; tb_we = 1'b1;
    @(negedge Clk);
    tb_we = 1'b0;
  endtask

  // Encrypt the padded message into 64..127 (even parity in bit 7) and scrub 0..63
  task automatic load_cipher(input logic [6:0] seed, input logic [6:0] tap,
                             input int pre, input int flip, input bit zero);
    logic [6:0] s, c;
    logic [7:0] cb;
    s = seed;
    for (int j = 0; j < 64; j++) begin
      c  = plain_at(j, pre) ^ s;
      cb = {^c, c};
      if (j == flip) cb = cb ^ 8'h04;
      if (zero) cb = 8'h00;
      tb_write(8'(64 + j), cb);
      s = step7(s, tap);
    end
    for (int j = 0; j < 64; j++) tb_write(8'(j), 8'hAA);
  endtask

  task automatic run_wait(input string tag);
    int cyc;
    bus.Start = 1'b1;
    repeat (2) @(negedge Clk);
    bus.Start = 1'b0;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (!bus.Ack && cyc < 400);
    chk_val({tag, "_ack"}, 32'(bus.Ack), 32'd1);
    chk_val({tag, "_latency_ok"}, 32'(cyc <= 356), 32'd1);
  endtask

  task automatic check_plain(input string tag, input int corrupt_pos);
    logic [7:0] exp;
    for (int w = 0; w < 64; w++) begin
      exp = (w < msg.len()) ? {1'b0, msg_chr(w)} : 8'h20;
      if (w == corrupt_pos) exp = {1'b1, msg_chr(w) ^ 7'h04};
      chk_val($sformatf("%s_mem[%0d]", tag, w), 32'(mem[w]), 32'(exp));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_val({tag, "_addr"},  32'(bus.mem_addr),  32'h0);
    chk_val({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'h0);
    chk_val({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
    chk_val({tag, "_ack"},   32'(bus.Ack),       32'h0);
    chk_val({tag, "_ptrn"},  32'(bus.ptrn_idx),  32'hF);
    chk_val({tag, "_nm"},    32'(bus.no_match),  32'h0);
  endtask

  initial begin
    int w0, a0, n;
    bus.Start = 1'b0;
    @(negedge Clk);
    load_cipher(7'h01, 7'h60, 10, -1, 1'b0);
    check_reset_outputs("reset");
    Reset = 1'b1;
    @(negedge Clk);

    // Start held high: nothing may move
    bus.Start = 1'b1;
    a0 = act_cnt;
    repeat (200) @(negedge Clk);
    chk_val("idle_activity", 32'(act_cnt - a0), 32'd0);
    chk_val("idle_ack", 32'(bus.Ack), 32'd0);

    // Pattern 0, seed 01, preamble 10
    w0 = wr_cnt;
    run_wait("p0");
    chk_val("p0_ptrn", 32'(bus.ptrn_idx), 32'd0);
    chk_val("p0_nm", 32'(bus.no_match), 32'd0);
    chk_val("p0_writes", 32'(wr_cnt - w0), 32'd64);
    check_plain("p0", -1);
    repeat (5) @(negedge Clk);
    chk_val("p0_hold_ack", 32'(bus.Ack), 32'd1);
    chk_val("p0_hold_ptrn", 32'(bus.ptrn_idx), 32'd0);

    // Pattern 8, seed 55, preamble 15
    load_cipher(7'h55, 7'h7B, 15, -1, 1'b0);
    w0 = wr_cnt;
    run_wait("p8");
    chk_val("p8_ptrn", 32'(bus.ptrn_idx), 32'd8);
    chk_val("p8_nm", 32'(bus.no_match), 32'd0);
    chk_val("p8_writes", 32'(wr_cnt - w0), 32'd64);
    check_plain("p8", -1);

    // Corrupted ciphertext byte 30 lands on plaintext index 20
    load_cipher(7'h01, 7'h60, 10, 30, 1'b0);
    run_wait("perr");
    chk_val("perr_ptrn", 32'(bus.ptrn_idx), 32'd0);
    check_plain("perr", 20);

    // All-zero ciphertext: no pattern fits
    load_cipher(7'h00, 7'h60, 0, -1, 1'b1);
    w0 = wr_cnt;
    run_wait("zero");
    chk_val("zero_nm", 32'(bus.no_match), 32'd1);
    chk_val("zero_ptrn", 32'(bus.ptrn_idx), 32'hF);
    chk_val("zero_writes", 32'(wr_cnt - w0), 32'd0);
    chk_val("zero_mem0", 32'(mem[0]), 32'hAA);

    // Reset mid-run, landing on a write cycle
    load_cipher(7'h01, 7'h60, 10, -1, 1'b0);
    bus.Start = 1'b1;
    repeat (2) @(negedge Clk);
    bus.Start = 1'b0;
    repeat (50) @(negedge Clk);
    n = 0;
    while (!bus.mem_wr_en && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk_val("midrun_wr_seen", 32'(bus.mem_wr_en), 32'd1);
    #2 Reset = 1'b0;
    #1 check_reset_outputs("midrun_rst");
    @(negedge Clk);
    Reset = 1'b1;
    load_cipher(7'h01, 7'h60, 10, -1, 1'b0);
    w0 = wr_cnt;
    run_wait("rerun");
    chk_val("rerun_ptrn", 32'(bus.ptrn_idx), 32'd0);
    chk_val("rerun_writes", 32'(wr_cnt - w0), 32'd64);
    check_plain("rerun", -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decrypt_sequencer.md
Name: decrypt_sequencer

Overview:
Hardware controller that runs the program-3 decryption job directly against the shared 256x8 data memory, with no instruction ROM. It searches the 9 legal LFSR tap patterns against the space preamble to recover pattern and seed. It then decrypts ciphertext at 64..127, strips leading spaces, flags parity errors in bit 7, and writes plaintext to 0..63. It sits beside TopLevel's data memory as an alternate memory master and uses the same Start/Ack handshake.

Parameters:
IN_BASE, 64, first ciphertext address
OUT_BASE, 0, first plaintext address
MSG_LEN, 64, bytes read and bytes written
CHECK_LEN, 9, preamble bytes 1..CHECK_LEN verified per candidate pattern
SPACE, 8'h20, preamble/pad character

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  high holds idle; high-to-low transition launches a run
mem_addr  out  8  data memory address
mem_wr_en  out  1  write strobe, one cycle per byte
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid one cycle after mem_addr is presented
Ack  out  1  run complete
ptrn_idx  out  4  winning pattern index 0..8; 4'hF if none
no_match  out  1  no candidate pattern fit the preamble

Behaviour:
- Reset low, asynchronous: state=IDLE, mem_addr=0, mem_wr_en=0, mem_wdata=0, Ack=0, ptrn_idx=4'hF, no_match=0. Takes effect mid-run, including mid-write: mem_wr_en drops immediately.
- Reads are 2 cycles: RD_ADDR drives mem_addr, RD_DATA samples mem_rdata. Writes are 1 cycle. Reads and writes never overlap.
- LFSR step: s_next = {s[5:0], ^(s & tap)}, 7 bits.
- IDLE: launch on sampled Start 1->0. Clear Ack and no_match, set ptrn_idx=4'hF.
- SEED: read IN_BASE. seed = rdata[6:0] ^ SPACE[6:0].
- SEARCH: for p = 0..8, set s=seed. For k = 1..CHECK_LEN: step s, read IN_BASE+k, test rdata[6:0]^s == 7'h20.
  - Any mismatch: abandon p and go to p+1.
  - All CHECK_LEN bytes pass: lock tap=TAPS[p], ptrn_idx=p, go to DECRYPT.
  - p=8 fails: no_match=1, go to DONE with zero memory writes.
- DECRYPT: i=0..MSG_LEN-1, s restarted at seed and stepped once per i.
  - Read IN_BASE+i. perr = ^rdata (odd parity over all 8 bits means corruption). pt = rdata[6:0]^s.
  - SKIP sub-mode (initial): drop the byte if pt==7'h20 and perr==0. Otherwise leave SKIP permanently and emit it. A corrupt byte always ends skipping.
  - Emit: write {perr, pt} to OUT_BASE+w, then w++.
- PAD: while w<MSG_LEN, write 8'h20 to OUT_BASE+w.
- DONE: Ack=1. Hold Ack, ptrn_idx and no_match until the next launch or reset. A Start low->high->low restarts from SEED.
- Start toggling during a run is ignored. Only IDLE/DONE sample it.
- All address arithmetic is 8-bit. IN_BASE+i never exceeds 127. w never exceeds MSG_LEN.
- Worst-case run: 2 + 9*CHECK_LEN*2 + MSG_LEN*3 cycles = 356 cycles with defaults.

Decomposition:
- Package decrypt_pkg: TAPS[9] = {7'h60,7'h48,7'h78,7'h72,7'h6A,7'h69,7'h5C,7'h7E,7'h7B}, SPACE, state enum {IDLE,SEED,SEARCH,DECRYPT,PAD,DONE}, read-phase enum {RD_ADDR,RD_DATA}.
- Sub-module lfsr7: load/step/tap inputs, 7-bit state out. Shared by SEARCH and DECRYPT.

Test Plan:
- "Mr. Watson, come here. I want to see you.", pattern 0, seed 7'h01, pre_length 10, no corruption -> ptrn_idx=0, mem[0..40]=message with bit7=0, mem[41..63]=8'h20, Ack=1, no_match=0.
- Same message, pattern 8 (7'h7B), seed 7'h55, pre_length 15 -> ptrn_idx=8, identical plaintext in 0..63.
- Bit 2 flipped in ciphertext byte 30 (pre 10, space 0) -> mem[20][7]=1; all other bytes exact.
- Ciphertext 64..127 all 8'h00 -> no_match=1, ptrn_idx=4'hF, Ack=1, no write strobes observed.
- Reset pulsed low at cycle 50 of a run -> all outputs zero immediately. A later Start high->low completes a correct run.
- Start held high for 200 cycles -> no memory activity and Ack=0. Start then falls -> Ack after at most 356 cycles.
